// File: rtl/i2s_stereo_tx.sv
// Stereo I2S playback serializer with a single-entry hold register and underrun/overrun flags.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (MSB at slot position 0).
module i2s_stereo_tx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned SCLK_HALF  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_l,
  input  logic [DATA_WIDTH-1:0] data_r,
  input  logic                  new_packet,
  output logic                  sclk,
  output logic                  lrck,
  output logic                  sdout,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, shift_l, shift_r, last_l, last_r;
  logic                  hold_valid;

  logic                  wrap, fall_tick, load, in_right, sdout_nx;
  logic [CNT_W-1:0]      next_bit, pos;
  logic [DATA_WIDTH-1:0] frame_l, frame_r, word, shifted;

  // Next serial bit is chosen from the pair that will own the frame after this tick,
  // so a boundary load and its first data bit can land on the same falling edge.
  always_comb begin
    wrap      = (div_cnt == DIV_W'(SCLK_HALF - 1));
    fall_tick = wrap && sclk;
    next_bit  = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);
    load      = fall_tick && (next_bit == '0);
    frame_l   = shift_l;
    frame_r   = shift_r;
    if (load) begin
      frame_l = hold_valid ? hold_l : last_l;
      frame_r = hold_valid ? hold_r : last_r;
    end
    in_right = (next_bit >= CNT_W'(SLOT_WIDTH));
    pos      = in_right ? next_bit - CNT_W'(SLOT_WIDTH) : next_bit;
    word     = in_right ? frame_r : frame_l;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    shifted  = word << pos;
    sdout_nx = (pos < CNT_W'(DATA_WIDTH)) && shifted[DATA_WIDTH-1];
`else
    shifted  = word << (pos - CNT_W'(1));
    sdout_nx = (pos != '0) && (pos <= CNT_W'(DATA_WIDTH)) && shifted[DATA_WIDTH-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk        <= 1'b0;
      lrck        <= 1'b0;
      sdout       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= CNT_W'(FRAME_BITS - 1);
      hold_l      <= '0;
      hold_r      <= '0;
      hold_valid  <= 1'b0;
      shift_l     <= '0;
      shift_r     <= '0;
      last_l      <= '0;
      last_r      <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      div_cnt     <= wrap ? '0 : div_cnt + DIV_W'(1);
      if (wrap) sclk <= ~sclk;
      if (fall_tick) begin
        bit_cnt <= next_bit;
        lrck    <= in_right;
        sdout   <= sdout_nx;
      end
      if (load) begin
        shift_l     <= frame_l;
        shift_r     <= frame_r;
        frame_start <= 1'b1;
        if (hold_valid) begin
          last_l <= hold_l;
          last_r <= hold_r;
        end else begin
          underrun <= 1'b1;
        end
      end
      // A capture on the boundary refills the entry the load just drained, so no overrun.
      if (new_packet) begin
        hold_l     <= data_l;
        hold_r     <= data_r;
        hold_valid <= 1'b1;
        if (hold_valid && !load) overrun <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx (DATA_WIDTH=24, SLOT_WIDTH=32, SCLK_HALF=4).
module tb_i2s_stereo_tx;

  logic        clk = 1'b0;
  logic        rst, new_packet;
  logic [23:0] data_l, data_r;
  logic        sclk, lrck, sdout, frame_start, underrun, overrun;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2s_stereo_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .SCLK_HALF(4)) dut (
    .clk(clk), .rst(rst), .data_l(data_l), .data_r(data_r), .new_packet(new_packet),
    .sclk(sclk), .lrck(lrck), .sdout(sdout), .frame_start(frame_start),
    .underrun(underrun), .overrun(overrun)
  );

  // send/dbl: pairs pushed during this frame; exp_*: what this frame must carry.
  typedef struct {
    logic        send;
    logic        dbl;
    logic [23:0] l, r, l2, r2;
    logic [23:0] exp_l, exp_r;
    logic        exp_under;
    int          exp_over;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot_exp(input logic [23:0] w);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return {w, 8'h00};
`else
    return {1'b0, w, 7'h00};
`endif
  endfunction

  task automatic wait_frame(input string name);
    int c;
    c = 0;
    while (frame_start !== 1'b1 && c < 1000) begin
      tick();
      c++;
    end
    if (frame_start !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: frame_start timeout", name);
    end
  endtask

  // Called right after frame_start is seen; samples sdout/lrck on each sclk rise.
  task automatic run_frame(input vec_t v, output logic [63:0] bits, output logic [63:0] ws,
                           output int ovr);
    int   rises, c;
    logic prev;
    rises = 0;
    c     = 0;
    ovr   = 0;
    bits  = '0;
    ws    = '0;
    prev  = sclk;
    while (rises < 64 && c < 600) begin
      tick();
      c++;
      if (overrun === 1'b1) ovr++;
      if (sclk === 1'b1 && prev === 1'b0) begin
        bits = {bits[62:0], sdout};
        ws   = {ws[62:0], lrck};
        rises++;
      end
      prev = sclk;
      if (c == 10 && v.send) begin
        new_packet = 1'b1; data_l = v.l;  data_r = v.r;
      end
      if (c == 20 && v.dbl) begin
        new_packet = 1'b1; data_l = v.l2; data_r = v.r2;
      end
      if (c == 11 || c == 21) new_packet = 1'b0;
    end
    if (rises < 64) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_capture: got %0d sclk rises expected 64", rises);
    end
  endtask

  task automatic check_frame(input string name, input vec_t v);
    logic [63:0] bits, ws;
    int          ovr;
    check({name, "_underrun"}, 64'(underrun), 64'(v.exp_under));
    run_frame(v, bits, ws, ovr);
    check({name, "_left"},  64'(bits[63:32]), 64'(slot_exp(v.exp_l)));
    check({name, "_right"}, 64'(bits[31:0]),  64'(slot_exp(v.exp_r)));
    check({name, "_lrck"},  ws, 64'h0000_0000_FFFF_FFFF);
    check({name, "_overrun"}, 64'(ovr), 64'(v.exp_over));
  endtask

  // From reset release: sclk rises at clk 4, first boundary with underrun at clk 8.
  task automatic startup(input string name);
    repeat (3) tick();
    check({name, "_sclk_clk3"}, 64'(sclk), 64'd0);
    tick();
    check({name, "_sclk_clk4"}, 64'(sclk), 64'd1);
    repeat (3) tick();
    check({name, "_fs_clk7"}, 64'(frame_start), 64'd0);
    tick();
    check({name, "_boundary_clk8"}, 64'({frame_start, underrun, sclk, lrck, sdout}), 64'b11000);
  endtask

  initial begin
    vec_t none;
    none = '{1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 0};
    vecs[0] = '{1'b1, 1'b0, 24'h800001, 24'h7FFFFE, 24'h0, 24'h0, 24'h000000, 24'h000000, 1'b1, 0};
    vecs[1] = '{1'b1, 1'b1, 24'h000001, 24'h111111, 24'h000002, 24'h222222,
                24'h800001, 24'h7FFFFE, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b0, 24'h123456, 24'h654321, 24'h0, 24'h0, 24'h000002, 24'h222222, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h123456, 24'h654321, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h123456, 24'h654321, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b0, 24'hABCDEF, 24'h012345, 24'h0, 24'h0, 24'h123456, 24'h654321, 1'b1, 0};

    rst = 1'b1; new_packet = 1'b0; data_l = '0; data_r = '0;
    repeat (3) tick();
    check("reset_outputs", 64'({sclk, lrck, sdout, frame_start, underrun, overrun}), 64'd0);
    rst = 1'b0;
    startup("start");

    for (int i = 0; i < 6; i++) begin
      wait_frame($sformatf("vec%0d_wait", i));
      check_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // new_packet on the exact boundary edge (frame_start was at c=0, boundary at c=512).
    repeat (3) tick();
    new_packet = 1'b1; data_l = 24'h0F0F0F; data_r = 24'hF0F0F0;
    tick();
    new_packet = 1'b0;
    check("collide_boundary", 64'({frame_start, underrun, overrun}), 64'b100);
    none.exp_l = 24'hABCDEF; none.exp_r = 24'h012345; none.exp_under = 1'b0;
    begin
      logic [63:0] bits, ws;
      int          ovr;
      run_frame(none, bits, ws, ovr);
      check("collide_old_left",  64'(bits[63:32]), 64'(slot_exp(24'hABCDEF)));
      check("collide_old_right", 64'(bits[31:0]),  64'(slot_exp(24'h012345)));
      check("collide_overrun",   64'(ovr), 64'd0);
    end
    wait_frame("collide_next_wait");
    none.exp_l = 24'h0F0F0F; none.exp_r = 24'hF0F0F0;
    check_frame("collide_new", none);

    // Reset in the middle of the right slot.
    wait_frame("midrst_wait");
    repeat (300) tick();
    check("midrst_in_right", 64'(lrck), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_outputs", 64'({sclk, lrck, sdout, frame_start, underrun, overrun}), 64'd0);
    rst = 1'b0;
    startup("recover");
    none.exp_l = 24'h0; none.exp_r = 24'h0; none.exp_under = 1'b1;
    check_frame("recover_frame", none);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
